// File: rtl/onehot_decoder_checker.sv
// Decodes the 3b->7b encoder word (one-hot-or-zero or Gray) to 3 bits, flags illegal words and mod-8 sequence breaks.
// Latency: one cycle, a word accepted at edge N is presented with out_valid = 1 from edge N onwards.
// Backpressure: single output register, in_ready = !out_valid || out_ready, so a stalled output blocks the input.
module onehot_decoder_checker #(
    parameter bit USE_GRAY  = 1'b0,
    parameter bit CHECK_SEQ = 1'b1,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_a,
    output logic             out_err,
    output logic             out_seq_err,
    input  logic             clr_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } seq_state_t;

    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    seq_state_t       state, state_next;
    logic [2:0]       prev, prev_next;
    logic [2:0]       prev_inc;
    logic [2:0]       dec_a;
    logic             dec_err;
    logic             seq_err_next;
    logic             accept;
    logic             inc;
    logic [ERR_W-1:0] cnt_base;
    logic [ERR_W-1:0] cnt_next;
    logic             sticky_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign prev_inc = prev + 3'd1;

    // Word decode; illegal words always decode to 0.
    always_comb begin
        dec_a   = 3'd0;
        dec_err = 1'b0;
        if (USE_GRAY) begin
            if (|in_code[6:3]) begin
                dec_err = 1'b1;
            end else begin
                dec_a = {in_code[2], in_code[2] ^ in_code[1], ^in_code[2:0]};
            end
        end else begin
            // x & (x-1) is non-zero exactly when two or more bits are set.
            if ((in_code & (in_code - 7'd1)) != 7'd0) begin
                dec_err = 1'b1;
            end else begin
                for (int k = 0; k < 7; k++) begin
                    if (in_code[k]) begin
                        dec_a = 3'(k + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
            prev  <= 3'd0;
        end else begin
            state <= state_next;
            prev  <= prev_next;
        end
    end

    // Sequence checker: resynchronises on every legal word, drops to SYNC on illegal ones.
    always_comb begin
        state_next   = state;
        prev_next    = prev;
        seq_err_next = 1'b0;
        if (CHECK_SEQ && accept) begin
            if (dec_err) begin
                state_next = SYNC;
            end else begin
                if (state == TRACK) begin
                    seq_err_next = (dec_a != prev_inc);
                end
                prev_next  = dec_a;
                state_next = TRACK;
            end
        end
    end

    // Clear takes effect before the current word is counted.
    assign inc         = accept && (dec_err || seq_err_next);
    assign cnt_base    = clr_err ? '0 : err_count;
    assign cnt_next    = (inc && (cnt_base != CNT_MAX)) ? cnt_base + ERR_W'(1) : cnt_base;
    assign sticky_next = (clr_err ? 1'b0 : err_sticky) || inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_a       <= 3'd0;
            out_err     <= 1'b0;
            out_seq_err <= 1'b0;
            err_sticky  <= 1'b0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_a       <= dec_a;
                out_err     <= dec_err;
                out_seq_err <= seq_err_next;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
            err_sticky <= sticky_next;
            err_count  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_checker.sv
// Bench for onehot_decoder_checker: one-hot instance driven from a vector table, Gray instance (ERR_W=2) by hand.
// Latency: checks are taken 1 time unit after the edge that accepted each word.
// Backpressure: exercised by a hand-written stall/release sequence on the one-hot instance.
module tb_onehot_decoder_checker;

    typedef struct {
        bit         rst;
        logic [6:0] code;
        logic [2:0] a;
        bit         err;
        bit         seq;
        int         cnt;
        bit         sticky;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [6:0] in_code;
    logic [2:0] out_a;
    logic       out_err, out_seq_err, clr_err, err_sticky;
    logic [7:0] err_count;

    logic       g_in_valid, g_in_ready, g_out_valid, g_out_ready;
    logic [6:0] g_in_code;
    logic [2:0] g_out_a;
    logic       g_out_err, g_out_seq_err, g_clr_err, g_err_sticky;
    logic [1:0] g_err_count;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    onehot_decoder_checker #(.USE_GRAY(1'b0), .CHECK_SEQ(1'b1), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_err(out_err),
        .out_seq_err(out_seq_err), .clr_err(clr_err), .err_sticky(err_sticky), .err_count(err_count)
    );

    onehot_decoder_checker #(.USE_GRAY(1'b1), .CHECK_SEQ(1'b1), .ERR_W(2)) dut_gray (
        .clk(clk), .rst_n(rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready), .in_code(g_in_code),
        .out_valid(g_out_valid), .out_ready(g_out_ready), .out_a(g_out_a), .out_err(g_out_err),
        .out_seq_err(g_out_seq_err), .clr_err(g_clr_err), .err_sticky(g_err_sticky), .err_count(g_err_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        g_in_valid = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] gcodes [8];
        int         exp_cnt;

        // One-hot sweep
        vecs.push_back(vec_t'{1, 7'd0,  3'd0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd1,  3'd1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd2,  3'd2, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd4,  3'd3, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd8,  3'd4, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd16, 3'd5, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd32, 3'd6, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd64, 3'd7, 0, 0, 0, 0});
        // Illegal word then resync
        vecs.push_back(vec_t'{1, 7'd1,  3'd1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd3,  3'd0, 1, 0, 1, 1});
        vecs.push_back(vec_t'{0, 7'd2,  3'd2, 0, 0, 1, 1});
        vecs.push_back(vec_t'{0, 7'd4,  3'd3, 0, 0, 1, 1});
        // Wrap 7->0 is legal, 0->2 is a sequence error, then resync on 2
        vecs.push_back(vec_t'{1, 7'd64, 3'd7, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd0,  3'd0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 7'd2,  3'd2, 0, 1, 1, 1});
        vecs.push_back(vec_t'{0, 7'd4,  3'd3, 0, 0, 1, 1});
        // Two high bits illegal, next legal word only resyncs
        vecs.push_back(vec_t'{0, 7'd96, 3'd0, 1, 0, 2, 1});
        vecs.push_back(vec_t'{0, 7'd8,  3'd4, 0, 0, 2, 1});

        gcodes = '{7'd0, 7'd1, 7'd3, 7'd2, 7'd6, 7'd7, 7'd5, 7'd4};

        rst_n = 1'b0;
        in_valid = 1'b0; in_code = 7'd0; out_ready = 1'b1; clr_err = 1'b0;
        g_in_valid = 1'b0; g_in_code = 7'd0; g_out_ready = 1'b1; g_clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_a", out_a, 0);
        chk("reset out_err", out_err, 0);
        chk("reset out_seq_err", out_seq_err, 0);
        chk("reset err_sticky", err_sticky, 0);
        chk("reset err_count", err_count, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset gray in_ready", g_in_ready, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            in_valid = 1'b1;
            in_code  = vecs[i].code;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), out_valid, 1);
            chk($sformatf("v%0d out_a", i), out_a, vecs[i].a);
            chk($sformatf("v%0d out_err", i), out_err, vecs[i].err);
            chk($sformatf("v%0d out_seq_err", i), out_seq_err, vecs[i].seq);
            chk($sformatf("v%0d err_count", i), err_count, vecs[i].cnt);
            chk($sformatf("v%0d err_sticky", i), err_sticky, vecs[i].sticky);
        end
        in_valid = 1'b0;

        // Backpressure: word 4 held for 3 stalled cycles, pending word 5 taken exactly once
        do_reset();
        in_valid = 1'b1; in_code = 7'd8;
        @(posedge clk);
        #1;
        chk("bp first out_a", out_a, 4);
        in_code = 7'd16; out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp stall%0d out_a", s), out_a, 4);
            chk($sformatf("bp stall%0d out_valid", s), out_valid, 1);
            chk($sformatf("bp stall%0d in_ready", s), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp next out_a", out_a, 5);
        chk("bp next out_seq_err", out_seq_err, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain out_valid", out_valid, 0);
        chk("drain out_a hold", out_a, 5);
        chk("drain err_count", err_count, 0);

        // Mid-stream reset discards the held word and restarts in SYNC
        in_valid = 1'b1; in_code = 7'd32; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst held out_a", out_a, 6);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_a", out_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_code = 7'd4;
        @(posedge clk);
        #1;
        chk("midrst first out_a", out_a, 3);
        chk("midrst first out_seq_err", out_seq_err, 0);
        in_valid = 1'b0;

        // Gray instance: sweep, saturation, clear
        do_reset();
        for (int i = 0; i < 8; i++) begin
            g_in_valid = 1'b1;
            g_in_code  = gcodes[i];
            @(posedge clk);
            #1;
            chk($sformatf("gray%0d out_a", i), g_out_a, i);
            chk($sformatf("gray%0d out_err", i), g_out_err, 0);
            chk($sformatf("gray%0d out_seq_err", i), g_out_seq_err, 0);
            chk($sformatf("gray%0d err_count", i), g_err_count, 0);
        end
        for (int i = 0; i < 5; i++) begin
            g_in_code = 7'b1000000;
            @(posedge clk);
            #1;
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            chk($sformatf("gsat%0d out_a", i), g_out_a, 0);
            chk($sformatf("gsat%0d out_err", i), g_out_err, 1);
            chk($sformatf("gsat%0d err_count", i), g_err_count, exp_cnt);
            chk($sformatf("gsat%0d err_sticky", i), g_err_sticky, 1);
        end
        g_clr_err = 1'b1;
        @(posedge clk);
        #1;
        chk("gclr+illegal err_count", g_err_count, 1);
        chk("gclr+illegal err_sticky", g_err_sticky, 1);
        g_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("gclr alone err_count", g_err_count, 0);
        chk("gclr alone err_sticky", g_err_sticky, 0);
        g_clr_err = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_checker.md
# onehot_decoder_checker

Registered consumer stage placed directly downstream of the 3-bit-to-7-bit code encoder. It accepts the encoder's 7-bit output word over a valid/ready handshake and decodes it back to the 3-bit source value. It flags illegal code words and optionally checks that consecutive words form an incrementing modulo-8 sequence. It also keeps a sticky error flag and a saturating error counter for bring-up and self-checking benches.

## Interface
- USE_GRAY, 0, input format: 0 = one-hot-or-zero word on in_code[6:0]; 1 = 3-bit Gray code on in_code[2:0], with in_code[6:3] required to be 0.
- CHECK_SEQ, 1, 1 = enable the modulo-8 increment sequence check; 0 = out_seq_err is tied to 0.
- ERR_W, 8, width of err_count.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_code is valid this cycle.
- in_ready  out  1  stage can accept in_code this cycle.
- in_code  in  7  encoder output word.
- out_valid  out  1  out_a, out_err and out_seq_err hold a decoded word.
- out_ready  in  1  downstream accepts the output word this cycle.
- out_a  out  3  decoded 3-bit value.
- out_err  out  1  word was illegal.
- out_seq_err  out  1  legal word broke the increment sequence.
- clr_err  in  1  synchronous clear of err_sticky and err_count.
- err_sticky  out  1  set by any accepted illegal word or sequence error.
- err_count  out  ERR_W  count of accepted illegal words plus sequence errors; saturates.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready is 1 when !out_valid || out_ready, so there is one output register with pass-through backpressure.
- One-hot decode (USE_GRAY=0):
  - 0000000 -> 0.
  - Only bit k set -> k+1 (bit0 -> 1, ..., bit6 -> 7).
  - Two or more bits set is illegal: out_a = 0, out_err = 1.
- Gray decode (USE_GRAY=1):
  - out_a = gray-to-binary of in_code[2:0] (000->0, 001->1, 011->2, 010->3, 110->4, 111->5, 101->6, 100->7).
  - Any bit of in_code[6:3] set is illegal: out_a = 0, out_err = 1.
- Sequence checker FSM (CHECK_SEQ=1), with a 3-bit prev register:
  - SYNC: waits for the first legal accepted word. That word is stored in prev, the FSM moves to TRACK, and out_seq_err = 0.
  - TRACK: for each legal accepted word, out_seq_err = (decoded != prev+1 mod 8). prev is then updated to the decoded value, so the checker resynchronises on the new value. The FSM stays in TRACK.
  - Wrap-around: 7 followed by 0 is legal.
  - An illegal accepted word in any state gives out_seq_err = 0, leaves prev unchanged, and moves the FSM to SYNC.
- Error accounting, per accepted word:
  - inc = out_err_next | out_seq_err_next. out_err and out_seq_err are mutually exclusive.
  - err_count += inc, saturating at 2^ERR_W-1.
  - err_sticky is set when inc = 1.
- clr_err:
  - Alone, clr_err zeroes err_count and err_sticky.
  - If it coincides with an accepted word that has inc = 1, the result is err_count = 1 and err_sticky = 1: clear first, then count.
  - clr_err does not affect the datapath or the FSM.

## Timing
- Reset (rst_n low, async) sets:
  - out_valid = 0, out_a = 0, out_err = 0, out_seq_err = 0.
  - err_sticky = 0, err_count = 0.
  - FSM = SYNC, prev = 0.
  - in_ready = 1 in the first cycle after reset.
- Latency: a word accepted at edge N is presented on out_* after edge N, with out_valid = 1 in cycle N+1.
- Output hold: while out_valid && !out_ready, out_* are held stable and in_ready = 0.
- Simultaneous handshakes: with out_valid && out_ready && in_valid, the new word replaces the old one in the same edge. Throughput is 1 word/clock.
- Output drain: with out_valid && out_ready && !in_valid, out_valid goes to 0 at the next edge and out_a keeps its last value.
- Flags are purely registered; no combinational path from in_code to outputs.
- Reset asserted mid-stream discards the held word and restarts the FSM in SYNC.

## Test plan
- Reset value check: hold rst_n = 0, then release → all outputs 0 and in_ready = 1.
- One-hot sweep (USE_GRAY=0, out_ready=1): feed 0,1,2,4,8,16,32,64 on consecutive clocks → out_a = 0..7, one cycle late, every cycle; out_err = 0; out_seq_err = 0; err_count = 0.
- Illegal and resync: feed 1,3,2,4 (decodes 1, illegal, 2, 3).
  - Word 2 gives out_a = 0, out_err = 1.
  - The FSM resyncs on 2, so 3 gives out_seq_err = 0.
  - Result: err_count = 1, err_sticky = 1.
- Sequence error and wrap: feed 64,0,2,4 (decodes 7,0,2,3).
  - Only word 2 (value 2) gives out_seq_err = 1.
  - Result: err_count = 1.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 and in_code = 8.
  - out_a = 4 stays stable and in_ready = 0.
  - On release, the next word is accepted with no loss or duplication.
- Gray mode, saturation and clear (USE_GRAY=1, ERR_W=2):
  - Gray 000,001,011,...,100 → out_a = 0..7 with no errors.
  - 5 words with in_code = 7'b1000000 → err_count saturates at 3.
  - clr_err together with one more illegal word → err_count = 1.
